spi_ram_arbiter: RTL and testbench
==================================

Name: spi_ram_arbiter

Overview:
- Shares one single-port RAM (10-bit command protocol) between two command requesters.
- Requester 0 is the SPI slave's receive path; requester 1 is a local host/BIST port.
- Command protocol: bits [9:8] 00 = write-address, 01 = write-data, 10 = read-address, 11 = read-data.
- Locks the RAM to one requester from its address command until the matching data command completes, so the RAM's internal address register is never corrupted. Read data is routed back to the lock owner.

Parameters:
- ADDR_SIZE, 8, RAM address/data width; command width is ADDR_SIZE+2.
- LOCK_TIMEOUT, 64, cycles a lock may idle before forced release (used only with ARB_LOCK_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req0_cmd, req1_cmd  in  ADDR_SIZE+2  command words
- req0_valid, req1_valid  in  1  command valid; must hold value until accepted
- req0_ready, req1_ready  out  1  combinational accept; acceptance = valid & ready
- req0_rdata, req1_rdata  out  ADDR_SIZE  read data return
- req0_rvalid, req1_rvalid  out  1  one-cycle read data strobe
- ram_din  out  ADDR_SIZE+2  command to RAM (registered)
- ram_rx_valid  out  1  one-cycle command strobe to RAM (registered)
- ram_dout  in  ADDR_SIZE  RAM read data
- ram_tx_valid  in  1  RAM read data valid
- grant_owner  out  1  current/last lock owner (0 or 1)
- busy  out  1  high in LOCKED or WAIT_RD
- cmd_err  out  1  one-cycle pulse: orphan data command dropped

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst). Reset mid-operation aborts any lock.
- Reset values: all outputs 0, state IDLE, round-robin pointer = req0, timeout counter 0.
- Forwarding latency: a command accepted in cycle N appears on ram_din with ram_rx_valid = 1 in cycle N+1. ram_din holds its value between strobes.
- IDLE:
  - A requester whose valid is high with cmd[9:8] in {00, 10} competes for the lock.
  - Single contender wins. If both contend, the pointer-favoured one wins; the loser's ready stays 0.
  - Winner is accepted and forwarded; grant_owner = winner; state -> LOCKED; pointer -> other requester.
- Orphan data commands in IDLE (cmd[9:8] in {01, 11}): ready = 1, command dropped (not forwarded), cmd_err pulses in cycle N+1. This may coincide with the other requester's address grant in the same cycle.
- LOCKED:
  - Owner ready = 1; non-owner ready = 0.
  - Owner address command: forwarded, lock kept, timeout counter cleared.
  - Owner 01: forwarded; state -> IDLE in N+1. New arbitration is possible in N+1.
  - Owner 11: forwarded; state -> WAIT_RD.
- WAIT_RD:
  - Both readies = 0.
  - On ram_tx_valid: reqX_rdata <= ram_dout and reqX_rvalid = 1 for the owner only, one cycle later; state -> IDLE.
  - ram_tx_valid outside WAIT_RD is ignored; rdata and rvalid are unchanged.
- Mismatched pairs (e.g. 10 then 01) are forwarded as-is; the data command type alone decides release.
- reqX_rdata holds its last value; rvalid is a one-cycle pulse.

Optional Feature:
- Macro: ARB_LOCK_TIMEOUT_EN.
- With the macro:
  - A counter increments each cycle in LOCKED or WAIT_RD without owner acceptance or ram_tx_valid.
  - At LOCK_TIMEOUT the lock is force-released: state -> IDLE, cmd_err pulses, counter cleared, no rvalid.
  - The counter clears on any owner acceptance.
- Without the macro: no counter; the lock persists until the data command (and, for reads, ram_tx_valid) completes. LOCK_TIMEOUT is unused.

Test Plan:
- rst = 1 for 3 cycles during req0 LOCKED -> all outputs 0 and IDLE; next req1 cmd 10'b00_00000101 accepted immediately.
- req0 sends 00_00000101 then 01_00000111 -> ram_din 0x005 then 0x107 with rx_valid pulses one cycle after each accept; busy falls after the second.
- req0 and req1 assert 00_00000011 in the same cycle after reset -> req0 wins; after req0's 01 completes, req1 is granted; on the next tie req0 wins again (pointer back to req0).
- req1 sends 10_00000011 then 11_00001000; RAM returns ram_dout = 0xA5 with tx_valid three cycles later -> req1_rdata = 0xA5, req1_rvalid pulses once, req0_rvalid stays 0; both readies 0 while waiting.
- req0 sends 01_00000111 in IDLE -> req0_ready = 1, no ram_rx_valid, cmd_err one-cycle pulse.
- With ARB_LOCK_TIMEOUT_EN and LOCK_TIMEOUT = 8: req0 sends 00_00000001 then goes silent -> forced release at 8 cycles, cmd_err pulses, req1's pending 10 command is granted the following cycle.

Source files
------------

// File: rtl/spi_ram_arbiter.sv
// Two-requester lock arbiter in front of a single-port command RAM; address/data pairs stay atomic.
// Optional idle-lock watchdog: define ARB_LOCK_TIMEOUT_EN (threshold LOCK_TIMEOUT).
module spi_ram_arbiter #(
   parameter int ADDR_SIZE    = 8,
   parameter int LOCK_TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ADDR_SIZE+1:0] req0_cmd,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   output logic [ADDR_SIZE-1:0] req0_rdata,
   output logic                 req0_rvalid,
   input  logic [ADDR_SIZE+1:0] req1_cmd,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   output logic [ADDR_SIZE-1:0] req1_rdata,
   output logic                 req1_rvalid,
   output logic [ADDR_SIZE+1:0] ram_din,
   output logic                 ram_rx_valid,
   input  logic [ADDR_SIZE-1:0] ram_dout,
   input  logic                 ram_tx_valid,
   output logic                 grant_owner,
   output logic                 busy,
   output logic                 cmd_err
);
   localparam int CW = ADDR_SIZE + 2;

   typedef enum logic [1:0] {S_IDLE, S_LOCKED, S_WAIT_RD} state_t;

   state_t               state_q;
   logic                 owner_q, ptr_q;
   logic [CW-1:0]        ram_din_q;
   logic                 ram_rx_valid_q, cmd_err_q;
   logic [ADDR_SIZE-1:0] rdata0_q, rdata1_q;
   logic                 rvalid0_q, rvalid1_q;

   logic          is_addr0, is_addr1, c0, c1;
   logic          grant_d, winner_d, drop_d, fwd_d, own_acc_d;
   logic          ready0_d, ready1_d;
   logic [CW-1:0] fwd_cmd_d;
   logic [1:0]    own_op_d;
   logic          timeout_fire;

   // Address commands (00, 10) have a zero in the low opcode bit.
   assign is_addr0 = ~req0_cmd[CW-2];
   assign is_addr1 = ~req1_cmd[CW-2];

   always_comb begin
      c0        = 1'b0;
      c1        = 1'b0;
      grant_d   = 1'b0;
      winner_d  = 1'b0;
      drop_d    = 1'b0;
      fwd_d     = 1'b0;
      own_acc_d = 1'b0;
      ready0_d  = 1'b0;
      ready1_d  = 1'b0;
      fwd_cmd_d = req0_cmd;
      case (state_q)
         S_IDLE: begin
            c0        = req0_valid & is_addr0;
            c1        = req1_valid & is_addr1;
            grant_d   = c0 | c1;
            winner_d  = c1 & (~c0 | ptr_q);
            // Orphan data commands are always taken so they cannot stall their requester.
            ready0_d  = ~is_addr0 | (c0 & ~winner_d);
            ready1_d  = ~is_addr1 | (c1 & winner_d);
            drop_d    = (req0_valid & ~is_addr0) | (req1_valid & ~is_addr1);
            fwd_d     = grant_d;
            fwd_cmd_d = winner_d ? req1_cmd : req0_cmd;
         end
         S_LOCKED: begin
            ready0_d  = ~owner_q;
            ready1_d  = owner_q;
            own_acc_d = owner_q ? req1_valid : req0_valid;
            fwd_d     = own_acc_d;
            fwd_cmd_d = owner_q ? req1_cmd : req0_cmd;
         end
         default: ;
      endcase
      if (rst) begin
         ready0_d = 1'b0;
         ready1_d = 1'b0;
      end
   end

   assign own_op_d = fwd_cmd_d[CW-1 -: 2];

`ifdef ARB_LOCK_TIMEOUT_EN
   localparam int TW = $clog2(LOCK_TIMEOUT + 1);
   logic [TW-1:0] to_cnt_q;
   logic          idle_tick;

   assign idle_tick    = ((state_q == S_LOCKED) && !own_acc_d) ||
                         ((state_q == S_WAIT_RD) && !ram_tx_valid);
   assign timeout_fire = idle_tick && (to_cnt_q == TW'(LOCK_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst || !idle_tick || timeout_fire) to_cnt_q <= '0;
      else                                   to_cnt_q <= to_cnt_q + 1'b1;
   end
`else
   // Locks never expire in this build; the threshold is deliberately ignored.
   assign timeout_fire = 1'b0 & LOCK_TIMEOUT[0];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         owner_q        <= 1'b0;
         ptr_q          <= 1'b0;
         ram_din_q      <= '0;
         ram_rx_valid_q <= 1'b0;
         cmd_err_q      <= 1'b0;
         rdata0_q       <= '0;
         rdata1_q       <= '0;
         rvalid0_q      <= 1'b0;
         rvalid1_q      <= 1'b0;
      end else begin
         ram_rx_valid_q <= fwd_d;
         if (fwd_d) ram_din_q <= fwd_cmd_d;
         cmd_err_q <= drop_d | timeout_fire;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (grant_d) begin
                  owner_q <= winner_d;
                  ptr_q   <= ~winner_d;
                  state_q <= S_LOCKED;
               end
            end
            S_LOCKED: begin
               if (own_acc_d) begin
                  if (own_op_d == 2'b01)      state_q <= S_IDLE;
                  else if (own_op_d == 2'b11) state_q <= S_WAIT_RD;
               end else if (timeout_fire) begin
                  state_q <= S_IDLE;
               end
            end
            S_WAIT_RD: begin
               if (ram_tx_valid) begin
                  if (owner_q) begin
                     rdata1_q  <= ram_dout;
                     rvalid1_q <= 1'b1;
                  end else begin
                     rdata0_q  <= ram_dout;
                     rvalid0_q <= 1'b1;
                  end
                  state_q <= S_IDLE;
               end else if (timeout_fire) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req0_ready   = ready0_d;
   assign req1_ready   = ready1_d;
   assign req0_rdata   = rdata0_q;
   assign req1_rdata   = rdata1_q;
   assign req0_rvalid  = rvalid0_q;
   assign req1_rvalid  = rvalid1_q;
   assign ram_din      = ram_din_q;
   assign ram_rx_valid = ram_rx_valid_q;
   assign grant_owner  = owner_q;
   assign busy         = (state_q != S_IDLE);
   assign cmd_err      = cmd_err_q;
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter: reset, write/read locking, tie-break, orphan drop, optional timeout.
module tb_spi_ram_arbiter;
   localparam int AW = 8;
   localparam int CW = AW + 2;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [CW-1:0] req0_cmd, req1_cmd;
   logic          req0_valid, req1_valid;
   logic          req0_ready, req1_ready;
   logic [AW-1:0] req0_rdata, req1_rdata;
   logic          req0_rvalid, req1_rvalid;
   logic [CW-1:0] ram_din;
   logic          ram_rx_valid;
   logic [AW-1:0] ram_dout;
   logic          ram_tx_valid;
   logic          grant_owner, busy, cmd_err;

   int n_chk = 0;
   int n_err = 0;

   spi_ram_arbiter #(.ADDR_SIZE(AW), .LOCK_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req0_cmd(req0_cmd), .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_rdata(req0_rdata), .req0_rvalid(req0_rvalid),
      .req1_cmd(req1_cmd), .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_rdata(req1_rdata), .req1_rvalid(req1_rvalid),
      .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
      .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid),
      .grant_owner(grant_owner), .busy(busy), .cmd_err(cmd_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      req0_cmd = '0; req1_cmd = '0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      ram_dout = '0; ram_tx_valid = 1'b0;
      step(); step();
      chk("rst_busy",   32'(busy),         32'd0);
      chk("rst_rx",     32'(ram_rx_valid), 32'd0);
      chk("rst_grant",  32'(grant_owner),  32'd0);
      chk("rst_err",    32'(cmd_err),      32'd0);
      chk("rst_rdata0", 32'(req0_rdata),   32'd0);
      rst = 1'b0;

      // reset in the middle of a req0 lock
      req0_valid = 1'b1; req0_cmd = 10'h005;
      #1 chk("lk_rdy0", 32'(req0_ready), 32'd1);
      step();
      chk("lk_busy", 32'(busy), 32'd1);
      req0_valid = 1'b0;
      rst = 1'b1;
      req1_valid = 1'b1; req1_cmd = 10'h005;
      #1 chk("rst_rdy1", 32'(req1_ready), 32'd0);
      step(); step(); step();
      chk("rst2_busy",  32'(busy),         32'd0);
      chk("rst2_rx",    32'(ram_rx_valid), 32'd0);
      chk("rst2_din",   32'(ram_din),      32'd0);
      chk("rst2_grant", 32'(grant_owner),  32'd0);
      chk("rst2_err",   32'(cmd_err),      32'd0);
      rst = 1'b0;
      #1 chk("post_rst_rdy1", 32'(req1_ready), 32'd1);
      step();
      chk("post_rst_din",   32'(ram_din),      32'h005);
      chk("post_rst_rx",    32'(ram_rx_valid), 32'd1);
      chk("post_rst_grant", 32'(grant_owner),  32'd1);
      req1_cmd = 10'h107;
      step();
      req1_valid = 1'b0;
      chk("post_rst_rel", 32'(busy), 32'd0);

      // tie-break with round-robin pointer
      rst = 1'b1; step(); rst = 1'b0;
      req0_valid = 1'b1; req0_cmd = 10'h003;
      req1_valid = 1'b1; req1_cmd = 10'h003;
      #1 chk("tie1_rdy0", 32'(req0_ready), 32'd1);
      chk("tie1_rdy1", 32'(req1_ready), 32'd0);
      step();
      chk("tie1_grant", 32'(grant_owner), 32'd0);
      chk("tie1_din",   32'(ram_din),     32'h003);
      req0_cmd = 10'h107;
      #1 chk("tie1_lk_rdy1", 32'(req1_ready), 32'd0);
      step();
      chk("tie1_din2", 32'(ram_din), 32'h107);
      chk("tie1_rel",  32'(busy),    32'd0);
      req0_valid = 1'b0;
      #1 chk("tie1_rdy1_next", 32'(req1_ready), 32'd1);
      step();
      chk("tie1_grant1", 32'(grant_owner), 32'd1);
      chk("tie1_din3",   32'(ram_din),     32'h003);
      req1_cmd = 10'h107;
      step();
      req1_valid = 1'b0;
      chk("tie1_rel1", 32'(busy), 32'd0);
      req0_valid = 1'b1; req0_cmd = 10'h003;
      req1_valid = 1'b1; req1_cmd = 10'h003;
      #1 chk("tie2_rdy0", 32'(req0_ready), 32'd1);
      chk("tie2_rdy1", 32'(req1_ready), 32'd0);
      step();
      chk("tie2_grant", 32'(grant_owner), 32'd0);
      req1_valid = 1'b0;
      req0_cmd = 10'h107;
      step();
      req0_valid = 1'b0;
      chk("tie2_rel", 32'(busy), 32'd0);

      // write pair from req0
      req0_valid = 1'b1; req0_cmd = 10'h005;
      step();
      chk("wr_din1",  32'(ram_din),      32'h005);
      chk("wr_rx1",   32'(ram_rx_valid), 32'd1);
      chk("wr_busy1", 32'(busy),         32'd1);
      req0_cmd = 10'h107;
      step();
      chk("wr_din2",  32'(ram_din),      32'h107);
      chk("wr_rx2",   32'(ram_rx_valid), 32'd1);
      chk("wr_busy2", 32'(busy),         32'd0);
      req0_valid = 1'b0;
      step();
      chk("wr_rx3",   32'(ram_rx_valid), 32'd0);
      chk("wr_hold",  32'(ram_din),      32'h107);

      // read pair from req1
      req1_valid = 1'b1; req1_cmd = 10'h203;
      #1 chk("rd_rdy1", 32'(req1_ready), 32'd1);
      step();
      chk("rd_din1",  32'(ram_din),     32'h203);
      chk("rd_grant", 32'(grant_owner), 32'd1);
      req1_cmd = 10'h308;
      step();
      chk("rd_din2", 32'(ram_din),      32'h308);
      chk("rd_rx2",  32'(ram_rx_valid), 32'd1);
      chk("rd_busy", 32'(busy),         32'd1);
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_cmd = 10'h003;
      #1 chk("rd_wait_rdy0", 32'(req0_ready), 32'd0);
      chk("rd_wait_rdy1", 32'(req1_ready), 32'd0);
      step();
      chk("rd_wait_rdy1b", 32'(req1_ready), 32'd0);
      step();
      ram_tx_valid = 1'b1; ram_dout = 8'hA5;
      step();
      ram_tx_valid = 1'b0;
      req0_valid = 1'b0;
      chk("rd_rdata1",  32'(req1_rdata),  32'hA5);
      chk("rd_rvalid1", 32'(req1_rvalid), 32'd1);
      chk("rd_rvalid0", 32'(req0_rvalid), 32'd0);
      chk("rd_rel",     32'(busy),        32'd0);
      step();
      chk("rd_pulse",  32'(req1_rvalid), 32'd0);
      chk("rd_hold",   32'(req1_rdata),  32'hA5);

      // stray RAM data outside WAIT_RD
      ram_tx_valid = 1'b1; ram_dout = 8'h3C;
      step();
      ram_tx_valid = 1'b0;
      chk("stray_rv1", 32'(req1_rvalid), 32'd0);
      chk("stray_rv0", 32'(req0_rvalid), 32'd0);
      chk("stray_rd1", 32'(req1_rdata),  32'hA5);
      chk("stray_rd0", 32'(req0_rdata),  32'd0);

      // orphan data command
      req0_valid = 1'b1; req0_cmd = 10'h107;
      #1 chk("orph_rdy0", 32'(req0_ready), 32'd1);
      step();
      req0_valid = 1'b0;
      chk("orph_rx",   32'(ram_rx_valid), 32'd0);
      chk("orph_err",  32'(cmd_err),      32'd1);
      chk("orph_busy", 32'(busy),         32'd0);
      step();
      chk("orph_err_pulse", 32'(cmd_err), 32'd0);

`ifdef ARB_LOCK_TIMEOUT_EN
      // forced release of a silent lock
      req0_valid = 1'b1; req0_cmd = 10'h001;
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_cmd = 10'h203;
      chk("to_busy0", 32'(busy), 32'd1);
      repeat (7) step();
      chk("to_busy7", 32'(busy),       32'd1);
      chk("to_err7",  32'(cmd_err),    32'd0);
      chk("to_rdy7",  32'(req1_ready), 32'd0);
      step();
      chk("to_rel",  32'(busy),       32'd0);
      chk("to_err",  32'(cmd_err),    32'd1);
      chk("to_rdy1", 32'(req1_ready), 32'd1);
      step();
      req1_valid = 1'b0;
      chk("to_grant", 32'(grant_owner),  32'd1);
      chk("to_din",   32'(ram_din),      32'h203);
      chk("to_rx",    32'(ram_rx_valid), 32'd1);
      chk("to_err2",  32'(cmd_err),      32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
